// File: rtl/spi_reg_config_if.sv
// SPI pins and configuration-register outputs of spi_reg_config, bundled as one port.
interface spi_reg_config_if;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;
    logic       frame_err;

    modport master (
        output sclk, copi, ncs,
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        input  pwm_duty_cycle, wr_strobe, frame_err
    );

    modport slave (
        input  sclk, copi, ncs,
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        output pwm_duty_cycle, wr_strobe, frame_err
    );
endinterface

// File: rtl/spi_reg_config.sv
// SPI mode-0 write-only configuration slave: 16-bit frames {wr, addr[6:0], data[7:0]}
// load one of five 8-bit registers; malformed frames are dropped with a frame_err pulse.
module spi_reg_config #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input  logic            clk,
    input  logic            rst,
    spi_reg_config_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

    localparam logic [4:0] CNT_FRAME  = 5'd16;
    localparam logic [4:0] CNT_SAT    = 5'd17;
    localparam logic [1:0] FLUSH_DONE = 2'(SYNC_STAGES);

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic                   sclk_prev_q, ncs_prev_q;
    logic [1:0]             flush_q;
    logic                   armed_q;
    logic [15:0]            shift_q, shift_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [7:0]             regs_q [5];
    logic                   wr_strobe_q, frame_err_q;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_rise, ncs_fall;
    logic                   frame_ok, frame_bad;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            flush_q     <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], bus.copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], bus.ncs};
            sclk_prev_q <= sclk_s;
            // ncs edge flop holds through COMMIT so a fall landing there is taken in IDLE
            if (state_q != COMMIT) ncs_prev_q <= ncs_s;
            // a frame already open at reset release stays ignored until ncs is seen high
            if (flush_q != FLUSH_DONE) flush_q <= flush_q + 2'd1;
            else if (ncs_s)            armed_q <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: blocking assignments, each target defaulted first, keep this block latch-free.
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (sclk_rise) begin
            shift_d = {shift_q[14:0], copi_s};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
    end

    // judged on the post-shift view so a final sclk rise coinciding with ncs rise counts
    assign frame_ok  = (cnt_d == CNT_FRAME) && shift_d[15] && (shift_d[14:8] <= MAX_ADDR);
    assign frame_bad = (cnt_d != CNT_FRAME) || (shift_d[15] && (shift_d[14:8] > MAX_ADDR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            // NOTE: the register file is reset explicitly; it drives live enables, not a RAM.
            for (int i = 0; i < 5; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ncs_fall && armed_q) begin
                        state_q <= SHIFT;
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_d;
                    if (ncs_rise) begin
                        state_q     <= COMMIT;
                        wr_strobe_q <= frame_ok;
                        frame_err_q <= frame_bad;
                    end
                end
                COMMIT: begin
                    if (wr_strobe_q) begin
                        case (shift_q[14:8])
                            7'h00:   regs_q[0] <= shift_q[7:0];
                            7'h01:   regs_q[1] <= shift_q[7:0];
                            7'h02:   regs_q[2] <= shift_q[7:0];
                            7'h03:   regs_q[3] <= shift_q[7:0];
                            7'h04:   regs_q[4] <= shift_q[7:0];
                            default: ;
                        endcase
                    end
                    wr_strobe_q <= 1'b0;
                    frame_err_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.en_reg_out_7_0  = regs_q[0];
    assign bus.en_reg_out_15_8 = regs_q[1];
    assign bus.en_reg_pwm_7_0  = regs_q[2];
    assign bus.en_reg_pwm_15_8 = regs_q[3];
    assign bus.pwm_duty_cycle  = regs_q[4];
    assign bus.wr_strobe       = wr_strobe_q;
    assign bus.frame_err       = frame_err_q;
endmodule
